ahb_resp_mux_dphase: RTL and testbench
======================================

Name: ahb_resp_mux_dphase

Overview:
- Parametrised AHB slave-to-master response multiplexer. Sits between N slave response ports and the single master.
- Registers the decoder's one-hot select at each accepted address phase and muxes HRDATA/HRESP/HREADY from the data-phase slave.
- Contains a built-in default slave that returns the two-cycle AHB ERROR response for unmapped or multiply-decoded addresses.
- Adds a per-transfer wait-state watchdog that aborts a hung slave with a two-cycle ERROR response.

Parameters:
- NUM_SLAVES, 4, number of slave response ports (1..16).
- DATA_W, 32, read data width.
- TIMEOUT, 16, maximum consecutive wait cycles before abort; 0 disables the watchdog.
- DEFAULT_RDATA, 32'hDEADBEEF, Hrdata driven when no slave owns the data phase (truncated/extended to DATA_W).

Ports:
- Hclk  in  1  bus clock.
- Hreset  in  1  asynchronous, active-high reset.
- Htrans  in  2  master HTRANS, address phase (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- Hsel  in  NUM_SLAVES  decoder select, address phase, expected one-hot.
- Hrdata_S  in  NUM_SLAVES*DATA_W  slave read data, slave i at bits [i*DATA_W +: DATA_W].
- Hresp_S  in  2*NUM_SLAVES  slave responses, 00 OKAY, 01 ERROR.
- Hreadyout_S  in  NUM_SLAVES  slave HREADYOUT.
- Hrdata  out  DATA_W  read data to master.
- Hresp  out  2  response to master.
- Hready  out  1  global HREADY, also fed back to all slaves as HREADYIN.
- dphase_sel  out  NUM_SLAVES  registered data-phase select, for debug and perf counters.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Clock and reset: one clock, Hclk. Hreset is asynchronous and active-high.
- Reset values: state=IDLE, dphase_sel=0, wait counter=0, timeout_err=0. In IDLE the combinational outputs are Hready=1, Hresp=00, Hrdata=DEFAULT_RDATA.
- Reset mid-transfer: return to IDLE immediately, whatever the state.
- Accept: an address phase is accepted on a rising edge with Hready=1 and Htrans[1]=1.
- States: IDLE, SLAVE, DERR1, DERR2, TERR1, TERR2.
- Next-state rule, evaluated whenever Hready=1 (IDLE, SLAVE on completion, DERR2, TERR2):
  - accept with Hsel one-hot -> SLAVE; dphase_sel<=Hsel; counter<=0.
  - accept with Hsel zero or multi-hot -> DERR1; dphase_sel<=0.
  - no accept (IDLE/BUSY) -> IDLE; dphase_sel<=0.
- IDLE: outputs as at reset.
- SLAVE, outputs: Hrdata/Hresp/Hready pass combinationally from slave k, where dphase_sel[k]=1. Zero added latency. Slave ERROR responses pass through unchanged.
- SLAVE, completion: when Hreadyout_S[k]=1, the transfer completes and the next-state rule applies.
- SLAVE, watchdog (TIMEOUT>0): while Hreadyout_S[k]=0, counter increments each cycle. If the counter equals TIMEOUT-1 and Hreadyout_S[k] is still 0, go to TERR1 with timeout_err=1 for that edge's following cycle. Slave k is then ignored for this transfer.
- TIMEOUT=0: the counter is held at 0 and TERR states are unreachable.
- DERR1/TERR1: Hready=0, Hresp=01, Hrdata=DEFAULT_RDATA. Always go to DERR2/TERR2 respectively.
- DERR2/TERR2: Hready=1, Hresp=01, Hrdata=DEFAULT_RDATA. The next-state rule applies, so back-to-back error-then-transfer works.
- Counter width: $clog2(TIMEOUT+1). No wrap is possible because of the abort.
- Simultaneous completion and timeout (Hreadyout_S[k] rises on the abort cycle): completion wins; no error.
- Hsel outside an accepted phase is ignored.

Test Plan:
- Reset and idle: assert Hreset mid-SLAVE wait -> same cycle Hready=1, Hresp=00, Hrdata=DEADBEEF, dphase_sel=0; after release, IDLE Htrans -> outputs unchanged.
- Pipelined routing: NONSEQ Hsel=0001, then SEQ Hsel=0100, both slaves ready. Slave0 data A5A5A5A5 appears in cycle 2 and slave2 data 12345678 in cycle 3, Hresp=00 throughout.
- Wait states: slave1 holds Hreadyout low 3 cycles, TIMEOUT=16 -> Hready low exactly 3 cycles, then data passes with OKAY; no timeout_err.
- Unmapped address: NONSEQ with Hsel=0000, then NONSEQ Hsel=0010 -> Hready 0,1 with Hresp=01,01. The Hsel=0010 transfer is accepted on the DERR2 edge, and slave1 data follows. Same result for Hsel=0011.
- Watchdog: slave3 stuck low, TIMEOUT=4 -> 4 wait cycles, then Hready=0/Hresp=01, then Hready=1/Hresp=01; timeout_err pulses once. A slave ERROR response passes through as 01.
- Boundary: Hreadyout rises on the 4th wait cycle with TIMEOUT=4 -> OKAY completion, no timeout_err. With TIMEOUT=0, a 100-cycle stall still completes with OKAY.

Source files
------------

// File: rtl/ahb_resp_mux_dphase.sv
// AHB slave-to-master response mux with built-in default slave and wait-state watchdog.
// Zero added latency in SLAVE; error responses take two cycles and stall via Hready=0.
module ahb_resp_mux_dphase #(
  parameter int                NUM_SLAVES    = 4,
  parameter int                DATA_W        = 32,
  parameter int                TIMEOUT       = 16,
  parameter logic [DATA_W-1:0] DEFAULT_RDATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                         Hclk,
  input  logic                         Hreset,
  input  logic [1:0]                   Htrans,
  input  logic [NUM_SLAVES-1:0]        Hsel,
  input  logic [NUM_SLAVES*DATA_W-1:0] Hrdata_S,
  input  logic [2*NUM_SLAVES-1:0]      Hresp_S,
  input  logic [NUM_SLAVES-1:0]        Hreadyout_S,
  output logic [DATA_W-1:0]            Hrdata,
  output logic [1:0]                   Hresp,
  output logic                         Hready,
  output logic [NUM_SLAVES-1:0]        dphase_sel,
  output logic                         timeout_err
);

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0]    RESP_OK  = 2'b00;
  localparam logic [1:0]    RESP_ERR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLAVE,
    ST_DERR1,
    ST_DERR2,
    ST_TERR1,
    ST_TERR2
  } state_t;

  state_t                state, state_nxt;
  logic [NUM_SLAVES-1:0] dphase_sel_nxt;
  logic [CW-1:0]         wait_cnt, wait_cnt_nxt;
  logic                  timeout_err_nxt;
  logic                  addr_ok;
  logic                  hsel_onehot;

  logic [DATA_W-1:0]     sel_rdata;
  logic [1:0]            sel_resp;
  logic                  sel_ready;

  assign hsel_onehot = (Hsel != '0) && ((Hsel & (Hsel - NUM_SLAVES'(1))) == '0);

  // dphase_sel is one-hot or zero, so an AND-OR mux is sufficient
  always_comb begin
    sel_rdata = '0;
    sel_resp  = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dphase_sel[i]) begin
        sel_rdata = sel_rdata | Hrdata_S[i*DATA_W +: DATA_W];
        sel_resp  = sel_resp  | Hresp_S[2*i +: 2];
        sel_ready = sel_ready | Hreadyout_S[i];
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    dphase_sel_nxt  = dphase_sel;
    wait_cnt_nxt    = wait_cnt;
    timeout_err_nxt = 1'b0;
    addr_ok         = 1'b0;
    Hready          = 1'b1;
    Hresp           = RESP_OK;
    Hrdata          = DEFAULT_RDATA;

    case (state)
      ST_IDLE: begin
        addr_ok = 1'b1;
      end
      ST_SLAVE: begin
        Hready = sel_ready;
        Hresp  = sel_resp;
        Hrdata = sel_rdata;
        if (sel_ready) begin
          addr_ok = 1'b1;
        end else if (TIMEOUT > 0) begin
          // completion on the last allowed cycle wins because sel_ready is tested first
          if (wait_cnt == CNT_LAST) begin
            state_nxt       = ST_TERR1;
            dphase_sel_nxt  = '0;
            wait_cnt_nxt    = '0;
            timeout_err_nxt = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + CW'(1);
          end
        end
      end
      ST_DERR1: begin
        Hready    = 1'b0;
        Hresp     = RESP_ERR;
        state_nxt = ST_DERR2;
      end
      ST_DERR2: begin
        Hresp   = RESP_ERR;
        addr_ok = 1'b1;
      end
      ST_TERR1: begin
        Hready    = 1'b0;
        Hresp     = RESP_ERR;
        state_nxt = ST_TERR2;
      end
      ST_TERR2: begin
        Hresp   = RESP_ERR;
        addr_ok = 1'b1;
      end
      default: begin
        state_nxt      = ST_IDLE;
        dphase_sel_nxt = '0;
      end
    endcase

    if (addr_ok) begin
      wait_cnt_nxt = '0;
      if (Htrans[1] && hsel_onehot) begin
        state_nxt      = ST_SLAVE;
        dphase_sel_nxt = Hsel;
      end else if (Htrans[1]) begin
        state_nxt      = ST_DERR1;
        dphase_sel_nxt = '0;
      end else begin
        state_nxt      = ST_IDLE;
        dphase_sel_nxt = '0;
      end
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state       <= ST_IDLE;
      dphase_sel  <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      dphase_sel  <= dphase_sel_nxt;
      wait_cnt    <= wait_cnt_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux_dphase.sv
// Directed bench for ahb_resp_mux_dphase; three instances cover TIMEOUT=16, 4 and 0.
module tb_ahb_resp_mux_dphase;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] D0 = 32'hA5A5A5A5;
  localparam logic [31:0] D1 = 32'hCAFEF00D;
  localparam logic [31:0] D2 = 32'h12345678;
  localparam logic [31:0] D3 = 32'h0BADF00D;

  logic         Hclk = 1'b0;
  logic         Hreset;
  logic [1:0]   Htrans;
  logic [3:0]   Hsel;
  logic [127:0] Hrdata_S;
  logic [7:0]   Hresp_S;
  logic [3:0]   Hreadyout_S;

  logic [31:0] rdata16, rdata4, rdata0;
  logic [1:0]  resp16, resp4, resp0;
  logic        rdy16, rdy4, rdy0;
  logic [3:0]  sel16, sel4, sel0;
  logic        terr16, terr4, terr0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Hclk = ~Hclk;

  assign Hrdata_S = {D3, D2, D1, D0};

  ahb_resp_mux_dphase #(.NUM_SLAVES(4), .DATA_W(32), .TIMEOUT(16)) dut16 (
    .Hclk(Hclk), .Hreset(Hreset), .Htrans(Htrans), .Hsel(Hsel), .Hrdata_S(Hrdata_S),
    .Hresp_S(Hresp_S), .Hreadyout_S(Hreadyout_S), .Hrdata(rdata16), .Hresp(resp16),
    .Hready(rdy16), .dphase_sel(sel16), .timeout_err(terr16));

  ahb_resp_mux_dphase #(.NUM_SLAVES(4), .DATA_W(32), .TIMEOUT(4)) dut4 (
    .Hclk(Hclk), .Hreset(Hreset), .Htrans(Htrans), .Hsel(Hsel), .Hrdata_S(Hrdata_S),
    .Hresp_S(Hresp_S), .Hreadyout_S(Hreadyout_S), .Hrdata(rdata4), .Hresp(resp4),
    .Hready(rdy4), .dphase_sel(sel4), .timeout_err(terr4));

  ahb_resp_mux_dphase #(.NUM_SLAVES(4), .DATA_W(32), .TIMEOUT(0)) dut0 (
    .Hclk(Hclk), .Hreset(Hreset), .Htrans(Htrans), .Hsel(Hsel), .Hrdata_S(Hrdata_S),
    .Hresp_S(Hresp_S), .Hreadyout_S(Hreadyout_S), .Hrdata(rdata0), .Hresp(resp0),
    .Hready(rdy0), .dphase_sel(sel0), .timeout_err(terr0));

  typedef struct packed {
    logic [1:0]  htrans;
    logic [3:0]  hsel;
    logic [3:0]  rdy;
    logic [7:0]  resp;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic [3:0]  e_sel;
    logic        e_terr;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inputs change on the falling edge; outputs are sampled 1ns later
  task automatic drive(input logic [1:0] t, input logic [3:0] s, input logic [3:0] r,
                       input logic [7:0] rs);
    @(negedge Hclk);
    Htrans      = t;
    Hsel        = s;
    Hreadyout_S = r;
    Hresp_S     = rs;
    #1;
  endtask

  task automatic do_reset();
    @(negedge Hclk);
    Hreset = 1'b1;
    Htrans = 2'b00; Hsel = 4'b0; Hreadyout_S = 4'hF; Hresp_S = 8'h00;
    @(negedge Hclk);
    Hreset = 1'b0;
  endtask

  initial begin
    int pulses;

    tbl[0]  = '{2'd2, 4'b0001, 4'hF, 8'h00, 1'b1, 2'b00, DB, 4'b0000, 1'b0};
    tbl[1]  = '{2'd3, 4'b0100, 4'hF, 8'h00, 1'b1, 2'b00, D0, 4'b0001, 1'b0};
    tbl[2]  = '{2'd0, 4'b0000, 4'hF, 8'h00, 1'b1, 2'b00, D2, 4'b0100, 1'b0};
    tbl[3]  = '{2'd0, 4'b0000, 4'hF, 8'h00, 1'b1, 2'b00, DB, 4'b0000, 1'b0};
    tbl[4]  = '{2'd2, 4'b0010, 4'hF, 8'h00, 1'b1, 2'b00, DB, 4'b0000, 1'b0};
    tbl[5]  = '{2'd2, 4'b1000, 4'hD, 8'h00, 1'b0, 2'b00, D1, 4'b0010, 1'b0};
    tbl[6]  = '{2'd2, 4'b1000, 4'hD, 8'h00, 1'b0, 2'b00, D1, 4'b0010, 1'b0};
    tbl[7]  = '{2'd2, 4'b1000, 4'hD, 8'h00, 1'b0, 2'b00, D1, 4'b0010, 1'b0};
    tbl[8]  = '{2'd0, 4'b0000, 4'hF, 8'h00, 1'b1, 2'b00, D1, 4'b0010, 1'b0};
    tbl[9]  = '{2'd0, 4'b0000, 4'hF, 8'h00, 1'b1, 2'b00, DB, 4'b0000, 1'b0};
    tbl[10] = '{2'd2, 4'b0000, 4'hF, 8'h00, 1'b1, 2'b00, DB, 4'b0000, 1'b0};
    tbl[11] = '{2'd0, 4'b0000, 4'hF, 8'h00, 1'b0, 2'b01, DB, 4'b0000, 1'b0};
    tbl[12] = '{2'd2, 4'b0010, 4'hF, 8'h00, 1'b1, 2'b01, DB, 4'b0000, 1'b0};
    tbl[13] = '{2'd0, 4'b0000, 4'hF, 8'h00, 1'b1, 2'b00, D1, 4'b0010, 1'b0};
    tbl[14] = '{2'd2, 4'b0011, 4'hF, 8'h00, 1'b1, 2'b00, DB, 4'b0000, 1'b0};
    tbl[15] = '{2'd0, 4'b0000, 4'hF, 8'h00, 1'b0, 2'b01, DB, 4'b0000, 1'b0};
    tbl[16] = '{2'd2, 4'b0010, 4'hF, 8'h00, 1'b1, 2'b01, DB, 4'b0000, 1'b0};
    tbl[17] = '{2'd0, 4'b0000, 4'hF, 8'h00, 1'b1, 2'b00, D1, 4'b0010, 1'b0};
    tbl[18] = '{2'd1, 4'b0001, 4'hF, 8'h00, 1'b1, 2'b00, DB, 4'b0000, 1'b0};
    tbl[19] = '{2'd0, 4'b0000, 4'hF, 8'h00, 1'b1, 2'b00, DB, 4'b0000, 1'b0};
    tbl[20] = '{2'd2, 4'b1000, 4'hF, 8'h00, 1'b1, 2'b00, DB, 4'b0000, 1'b0};
    tbl[21] = '{2'd0, 4'b0000, 4'h7, 8'h40, 1'b0, 2'b01, D3, 4'b1000, 1'b0};
    tbl[22] = '{2'd0, 4'b0000, 4'hF, 8'h40, 1'b1, 2'b01, D3, 4'b1000, 1'b0};
    tbl[23] = '{2'd0, 4'b0000, 4'hF, 8'h00, 1'b1, 2'b00, DB, 4'b0000, 1'b0};

    Hreset = 1'b1;
    Htrans = 2'b00; Hsel = 4'b0; Hreadyout_S = 4'hF; Hresp_S = 8'h00;
    repeat (2) @(posedge Hclk);
    #1;
    chk("rst_hready", 32'(rdy16), 32'd1);
    chk("rst_hresp",  32'(resp16), 32'd0);
    chk("rst_hrdata", rdata16, DB);
    chk("rst_dsel",   32'(sel16), 32'd0);
    chk("rst_terr",   32'(terr16), 32'd0);
    @(negedge Hclk);
    Hreset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].htrans, tbl[i].hsel, tbl[i].rdy, tbl[i].resp);
      chk($sformatf("vec%0d_hready", i), 32'(rdy16),  32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_hresp",  i), 32'(resp16), 32'(tbl[i].e_resp));
      chk($sformatf("vec%0d_hrdata", i), rdata16,     tbl[i].e_rdata);
      chk($sformatf("vec%0d_dsel",   i), 32'(sel16),  32'(tbl[i].e_sel));
      chk($sformatf("vec%0d_terr",   i), 32'(terr16), 32'(tbl[i].e_terr));
    end

    // asynchronous reset in the middle of a wait state
    do_reset();
    drive(2'd2, 4'b0010, 4'hF, 8'h00);
    drive(2'd0, 4'b0000, 4'hD, 8'h00);
    chk("midrst_wait_hready", 32'(rdy16), 32'd0);
    Hreset = 1'b1;
    #1;
    chk("midrst_hready", 32'(rdy16), 32'd1);
    chk("midrst_hresp",  32'(resp16), 32'd0);
    chk("midrst_hrdata", rdata16, DB);
    chk("midrst_dsel",   32'(sel16), 32'd0);
    @(negedge Hclk);
    Hreset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(2'd0, 4'b0000, 4'hF, 8'h00);
      chk($sformatf("postrst%0d_hready", i), 32'(rdy16), 32'd1);
      chk($sformatf("postrst%0d_hrdata", i), rdata16, DB);
      chk($sformatf("postrst%0d_dsel", i), 32'(sel16), 32'd0);
    end

    // watchdog abort of a stuck slave3, TIMEOUT=4
    do_reset();
    pulses = 0;
    drive(2'd2, 4'b1000, 4'hF, 8'h00);
    for (int w = 0; w < 4; w++) begin
      drive(2'd0, 4'b0000, 4'h7, 8'h00);
      pulses += int'(terr4);
      chk($sformatf("wd_wait%0d_hready", w), 32'(rdy4), 32'd0);
      chk($sformatf("wd_wait%0d_hresp", w), 32'(resp4), 32'd0);
    end
    drive(2'd0, 4'b0000, 4'h7, 8'h00);
    pulses += int'(terr4);
    chk("wd_terr1_hready", 32'(rdy4), 32'd0);
    chk("wd_terr1_hresp",  32'(resp4), 32'd1);
    chk("wd_terr1_hrdata", rdata4, DB);
    chk("wd_terr1_pulse",  32'(terr4), 32'd1);
    chk("wd_terr1_dsel",   32'(sel4), 32'd0);
    drive(2'd0, 4'b0000, 4'h7, 8'h00);
    pulses += int'(terr4);
    chk("wd_terr2_hready", 32'(rdy4), 32'd1);
    chk("wd_terr2_hresp",  32'(resp4), 32'd1);
    drive(2'd0, 4'b0000, 4'h7, 8'h00);
    pulses += int'(terr4);
    chk("wd_idle_hresp",   32'(resp4), 32'd0);
    chk("wd_pulse_count",  32'(pulses), 32'd1);

    // completion on the last allowed cycle wins over the abort
    do_reset();
    pulses = 0;
    drive(2'd2, 4'b1000, 4'hF, 8'h00);
    for (int w = 0; w < 3; w++) begin
      drive(2'd0, 4'b0000, 4'h7, 8'h00);
      pulses += int'(terr4);
      chk($sformatf("bnd_wait%0d_hready", w), 32'(rdy4), 32'd0);
    end
    drive(2'd0, 4'b0000, 4'hF, 8'h00);
    pulses += int'(terr4);
    chk("bnd_done_hready", 32'(rdy4), 32'd1);
    chk("bnd_done_hresp",  32'(resp4), 32'd0);
    chk("bnd_done_hrdata", rdata4, D3);
    drive(2'd0, 4'b0000, 4'hF, 8'h00);
    pulses += int'(terr4);
    chk("bnd_after_dsel",  32'(sel4), 32'd0);
    chk("bnd_after_hresp", 32'(resp4), 32'd0);
    chk("bnd_pulse_count", 32'(pulses), 32'd0);

    // watchdog disabled: a 100-cycle stall still completes OKAY
    do_reset();
    pulses = 0;
    drive(2'd2, 4'b0100, 4'hF, 8'h00);
    for (int w = 0; w < 100; w++) begin
      drive(2'd0, 4'b0000, 4'hB, 8'h00);
      pulses += int'(terr0);
      chk($sformatf("t0_wait%0d_hready", w), 32'(rdy0), 32'd0);
    end
    drive(2'd0, 4'b0000, 4'hF, 8'h00);
    chk("t0_done_hready", 32'(rdy0), 32'd1);
    chk("t0_done_hresp",  32'(resp0), 32'd0);
    chk("t0_done_hrdata", rdata0, D2);
    chk("t0_pulse_count", 32'(pulses), 32'd0);
    drive(2'd0, 4'b0000, 4'hF, 8'h00);
    chk("t0_idle_dsel",   32'(sel0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
